// File: rtl/alarm_scheduler_if.sv
// Alarm scheduler bus: sensor requests and mute in, buzzer/status out.
// master = request source (sensors, mute); slave = alarm_scheduler.
interface alarm_scheduler_if;
    logic       sensor1;
    logic       sensor2;
    logic       sensor3;
    logic       mute;
    logic       buzzer1;
    logic       buzzer2;
    logic       buzzer3;
    logic       active;
    logic [2:0] pending;
    logic [1:0] grant_id;

    modport master (
        output sensor1, sensor2, sensor3, mute,
        input  buzzer1, buzzer2, buzzer3, active, pending, grant_id
    );

    modport slave (
        input  sensor1, sensor2, sensor3, mute,
        output buzzer1, buzzer2, buzzer3, active, pending, grant_id
    );
endinterface

// File: rtl/alarm_scheduler.sv
// Three-sensor alarm scheduler: latches level requests, grants one buzzer
// at a time for ON_CYCLES, then stays silent for GAP_CYCLES before the next
// grant. Arbitration is round-robin by default; defining
// ALARM_SCHEDULER_FIXED_PRIO_EN selects fixed priority sensor1 > sensor2 > sensor3.
module alarm_scheduler #(
    parameter int unsigned ON_CYCLES  = 8,
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    alarm_scheduler_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SOUND = 2'd1,
        GAP   = 2'd2
    } state_t;

    // Counters are loaded with N-1 so a phase lasts exactly N cycles and
    // ON_CYCLES=1 loads zero instead of underflowing.
    localparam logic [7:0] ON_LOAD  = 8'(ON_CYCLES - 1);
    localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES - 1);

    state_t     state;
    logic [7:0] count;
    logic [2:0] pend;
    logic [2:0] buzz;
    logic       act;
    logic [1:0] gid;
    logic [2:0] sens;
    logic [1:0] winner;
    logic [2:0] grant_mask;

`ifndef ALARM_SCHEDULER_FIXED_PRIO_EN
    logic [1:0] last;
    logic       found;
    logic [1:0] pos;
`endif

    assign sens = {bus.sensor3, bus.sensor2, bus.sensor1};

    assign bus.buzzer1  = buzz[0];
    assign bus.buzzer2  = buzz[1];
    assign bus.buzzer3  = buzz[2];
    assign bus.active   = act;
    assign bus.pending  = pend;
    assign bus.grant_id = gid;

`ifdef ALARM_SCHEDULER_FIXED_PRIO_EN
    // Fixed priority: lowest sensor index wins.
    always_comb begin
        winner = 2'd0;
        if (pend[0])      winner = 2'd1;
        else if (pend[1]) winner = 2'd2;
        else if (pend[2]) winner = 2'd3;
    end
`else
    // Round-robin: search starts just after the last granted index, wrapping 3->1.
    always_comb begin
        winner = 2'd0;
        found  = 1'b0;
        pos    = 2'd0;
        for (int unsigned k = 0; k < 3; k++) begin
            pos = 2'((32'(last) + k) % 3);
            if (!found && pend[pos]) begin
                winner = pos + 2'd1;
                found  = 1'b1;
            end
        end
    end
`endif

    // One-hot of the request being granted this edge (only when IDLE).
    always_comb begin
        grant_mask = '0;
        if (state == IDLE && winner != 2'd0)
            grant_mask[winner - 2'd1] = 1'b1;
    end

    // Scheduler FSM with registered buzzer, grant and pending outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            count <= '0;
            pend  <= '0;
            buzz  <= '0;
            act   <= 1'b0;
            gid   <= '0;
`ifndef ALARM_SCHEDULER_FIXED_PRIO_EN
            last  <= 2'd3;
`endif
        end else if (bus.mute) begin
            state <= IDLE;
            count <= '0;
            pend  <= '0;
            buzz  <= '0;
            act   <= 1'b0;
            gid   <= '0;
        end else begin
            // A new sample of sensor_i overrides the clear from its own grant.
            pend <= (pend & ~grant_mask) | sens;
            unique case (state)
                IDLE: begin
                    if (winner != 2'd0) begin
                        state <= SOUND;
                        count <= ON_LOAD;
                        buzz  <= grant_mask;
                        gid   <= winner;
                        act   <= 1'b1;
`ifndef ALARM_SCHEDULER_FIXED_PRIO_EN
                        last  <= winner;
`endif
                    end
                end
                SOUND: begin
                    if (count == 8'd0) begin
                        buzz <= '0;
                        gid  <= '0;
                        if (GAP_CYCLES == 0) begin
                            state <= IDLE;
                            act   <= 1'b0;
                        end else begin
                            state <= GAP;
                            count <= GAP_LOAD;
                        end
                    end else begin
                        count <= count - 8'd1;
                    end
                end
                GAP: begin
                    if (count == 8'd0) begin
                        state <= IDLE;
                        act   <= 1'b0;
                    end else begin
                        count <= count - 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    buzz  <= '0;
                    gid   <= '0;
                    act   <= 1'b0;
                end
            endcase
        end
    end

endmodule
